// File: rtl/cover_pkg.sv
// Shared constants and types for the toggle-cover arbiter slice.
package cover_pkg;
   localparam int COVER_TOTAL = 9715;
   localparam int COVER_IDX_W = 16;
   localparam int MERGE_CNT_W = 16;

   typedef logic [COVER_IDX_W-1:0] cover_idx_t;
endpackage

// File: rtl/cover_rr_arbiter.sv
// Round-robin port selector: highest priority is the port at ptr_i, wrapping upward.
module cover_rr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int PTR_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [PTR_W-1:0]     ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PTR_W-1:0]     ptr_next_o
);

   int   p;
   logic found;

   always_comb begin
      gnt_o      = '0;
      ptr_next_o = ptr_i;
      found      = 1'b0;
      p          = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         p = int'(ptr_i) + k;
         if (p >= NUM_PORTS) p = p - NUM_PORTS;
         if (!found && req_i[p]) begin
            found      = 1'b1;
            gnt_o[p]   = 1'b1;
            // next search starts just past the winner
            ptr_next_o = (p == NUM_PORTS - 1) ? '0 : PTR_W'(p + 1);
         end
      end
   end

endmodule

// File: rtl/cover_toggle_arbiter.sv
// Collects per-bit toggle-cover hits into pending flags and streams their indices out.
// Optional build macro COVER_DEDUP_EN: each index is reported at most once between resets.
module cover_toggle_arbiter
   import cover_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int PORT_W     = 4,
   parameter int IDX_W      = 16,
   parameter int COVER_BASE = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_PORTS*PORT_W-1:0] valid,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [IDX_W-1:0]            out_index,
   output logic [MERGE_CNT_W-1:0]      merged_cnt,
   output logic                        busy
);

   localparam int NB    = NUM_PORTS * PORT_W;
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NB-1:0]          pend_q, pend_d, hit, sel, clr, merge;
   logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_next;
   logic [NUM_PORTS-1:0]   req, gnt;
   logic                   out_valid_q, out_valid_d, load, any_pend, found;
   logic [IDX_W-1:0]       out_index_q, out_index_d, sel_idx;
   logic [MERGE_CNT_W-1:0] merged_q, merged_d;
`ifdef COVER_DEDUP_EN
   logic [NB-1:0]          mask_q, mask_d;
`endif

   function automatic logic [MERGE_CNT_W-1:0] popcnt(input logic [NB-1:0] v);
      logic [MERGE_CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NB; i++) c = c + MERGE_CNT_W'(v[i]);
      return c;
   endfunction

   function automatic logic [MERGE_CNT_W-1:0] sat_add(input logic [MERGE_CNT_W-1:0] a,
                                                      input logic [MERGE_CNT_W-1:0] b);
      logic [MERGE_CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[MERGE_CNT_W] ? '1 : s[MERGE_CNT_W-1:0];
   endfunction

   always_comb begin
      req = '0;
      for (int p = 0; p < NUM_PORTS; p++) req[p] = |pend_q[p*PORT_W +: PORT_W];
   end

   cover_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_rr (
      .req_i      (req),
      .ptr_i      (ptr_q),
      .gnt_o      (gnt),
      .ptr_next_o (ptr_next)
   );

   // lowest pending bit inside the granted port
   always_comb begin
      sel     = '0;
      sel_idx = out_index_q;
      found   = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int b = 0; b < PORT_W; b++) begin
            if (!found && gnt[p] && pend_q[p*PORT_W+b]) begin
               found              = 1'b1;
               sel[p*PORT_W+b]    = 1'b1;
               sel_idx            = IDX_W'(COVER_BASE + p*PORT_W + b);
            end
         end
      end
   end

   assign any_pend = |pend_q;
   assign load     = !out_valid_q || out_ready;
   assign clr      = (load && any_pend) ? sel : '0;

`ifdef COVER_DEDUP_EN
   assign hit    = enable ? (valid & ~mask_q) : '0;
   assign mask_d = mask_q | hit;
`else
   assign hit    = enable ? valid : '0;
`endif

   // a hit on a flag being cleared this edge re-arms it instead of merging
   assign merge    = hit & pend_q & ~clr;
   assign pend_d   = (pend_q & ~clr) | hit;
   assign merged_d = sat_add(merged_q, popcnt(merge));

   always_comb begin
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = any_pend;
         if (any_pend) begin
            out_index_d = sel_idx;
            ptr_d       = ptr_next;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pend_q      <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         merged_q    <= '0;
`ifdef COVER_DEDUP_EN
         mask_q      <= '0;
`endif
      end else begin
         pend_q      <= pend_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         merged_q    <= merged_d;
`ifdef COVER_DEDUP_EN
         mask_q      <= mask_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_index  = out_index_q;
   assign merged_cnt = merged_q;
   assign busy       = any_pend | out_valid_q;

endmodule

// File: tb/tb_cover_toggle_arbiter.sv
// Directed and randomized bench for cover_toggle_arbiter against a behavioural flag model.
module tb_cover_toggle_arbiter;

   localparam int NP   = 4;
   localparam int PW   = 4;
   localparam int NB   = NP * PW;
   localparam int BASE = 0;

   logic          clock = 1'b0;
   logic          reset, enable, out_ready, out_valid, busy;
   logic [NB-1:0] valid;
   logic [15:0]   out_index, merged_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_pend[NB];
   bit m_mask[NB];
   int m_last;
   bit m_ov;
   int m_idx;
   int m_merged;
   int rep[NB];

`ifdef COVER_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   cover_toggle_arbiter #(
      .NUM_PORTS  (NP),
      .PORT_W     (PW),
      .IDX_W      (16),
      .COVER_BASE (BASE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .valid      (valid),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .merged_cnt (merged_cnt),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // one clock: predict from current inputs, take the edge, then compare
   task automatic step();
      bit n_pend[NB];
      bit n_mask[NB];
      int n_last, n_idx, n_merged, sel, p;
      bit n_ov, h, any;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready && out_index < NB) rep[out_index]++;
      n_pend = m_pend; n_mask = m_mask; n_last = m_last; n_ov = m_ov;
      n_idx = m_idx; n_merged = m_merged; sel = -1;
      if (!reset) begin
         for (int i = 0; i < NB; i++) begin n_pend[i] = 0; n_mask[i] = 0; end
         n_last = NP - 1; n_ov = 0; n_idx = 0; n_merged = 0;
      end else begin
         if (!m_ov || out_ready) begin
            n_ov = 0;
            for (int k = 1; k <= NP && sel < 0; k++) begin
               p = (m_last + k) % NP;
               for (int b = 0; b < PW && sel < 0; b++)
                  if (m_pend[p*PW+b]) begin sel = p*PW + b; n_last = p; end
            end
            if (sel >= 0) begin n_ov = 1; n_idx = (BASE + sel) % 65536; end
         end
         for (int i = 0; i < NB; i++) begin
            h = enable && valid[i] && !(DEDUP && m_mask[i]);
            if (h && m_pend[i] && i != sel && n_merged < 65535) n_merged++;
            n_pend[i] = (m_pend[i] && i != sel) || h;
            n_mask[i] = m_mask[i] || h;
         end
      end
      @(posedge clock);
      #1;
      m_pend = n_pend; m_mask = n_mask; m_last = n_last; m_ov = n_ov;
      m_idx = n_idx; m_merged = n_merged;
      any = 0;
      for (int i = 0; i < NB; i++) any |= m_pend[i];
      check("model_out_valid", out_valid, m_ov);
      check("model_out_index", out_index, m_idx);
      check("model_merged", merged_cnt, m_merged);
      check("model_busy", busy, any || m_ov);
   endtask

   task automatic do_reset();
      reset = 1'b0; valid = '0;
      step();
      reset = 1'b1;
      for (int i = 0; i < NB; i++) rep[i] = 0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; valid = '0; out_ready = 1'b0;
      for (int i = 0; i < NB; i++) begin m_pend[i] = 0; m_mask[i] = 0; rep[i] = 0; end
      m_last = NP - 1; m_ov = 0; m_idx = 0; m_merged = 0;
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_merged", merged_cnt, 0);
      check("rst_out_index", out_index, 0);
      reset = 1'b1; enable = 1'b1;

      // single hit latency
      do_reset();
      out_ready = 1'b1; valid = 16'h0040;
      step(); valid = '0;
      check("single_n1_valid", out_valid, 0);
      step();
      check("single_n2_valid", out_valid, 1);
      check("single_n2_index", out_index, 6);
      step();
      check("single_n3_valid", out_valid, 0);

      // round-robin across ports 0, 1, 3
      do_reset();
      valid = 16'h1011;
      step(); valid = '0;
      step();
      check("rr_first", out_index, 0);
      step();
      check("rr_second", out_index, 4);
      check("rr_second_valid", out_valid, 1);
      step();
      check("rr_third", out_index, 12);
      step();
      check("rr_drained", out_valid, 0);

      // backpressure holds index 2
      do_reset();
      out_ready = 1'b0; valid = 16'h0004;
      step(); valid = '0;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_index", out_index, 2);
         check("bp_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      step(); step();
      check("bp_accept_once", rep[2], 1);
      check("bp_after_valid", out_valid, 0);

      // merge while output is stalled
      do_reset();
      out_ready = 1'b0; valid = 16'h0004;
      step(); valid = '0;
      step();
      valid = 16'h0002;
      step(); step(); step();
      valid = '0;
      step();
      check("merge_cnt", merged_cnt, 2);
      out_ready = 1'b1;
      repeat (4) step();
      check("merge_idx1_once", rep[1], 1);
      check("merge_idx2_once", rep[2], 1);

      // reset with eight flags pending
      do_reset();
      out_ready = 1'b0; valid = 16'h00FF;
      step(); step();
      valid = '0;
      step();
      check("pre_rst_busy", busy, 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_merged", merged_cnt, 0);

      // randomized traffic with occasional resets
      do_reset();
      for (int c = 0; c < 600; c++) begin
         valid     = NB'($urandom & $urandom & $urandom);
         enable    = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         reset     = ($urandom % 150) != 0;
         step();
      end
      reset = 1'b1; enable = 1'b1;

      // same bit hit twice, ten cycles apart
      do_reset();
      out_ready = 1'b1; valid = 16'h0020;
      step(); valid = '0;
      repeat (10) step();
      valid = 16'h0020;
      step(); valid = '0;
      repeat (6) step();
      check("dedup_reports", rep[5], DEDUP ? 1 : 2);

      // merged counter saturation
      do_reset();
      out_ready = 1'b0; valid = '1;
      repeat (4200) step();
      valid = '0;
      check("merged_saturate", merged_cnt, DEDUP ? 0 : 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cover_toggle_arbiter.md
COVER_TOGGLE_ARBITER -- requirements
Module: cover_toggle_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_PORTS, 4, number of toggle-cover requester ports.
- PORT_W, 4, valid bits per port.
- IDX_W, 16, width of the reported cover index.
- COVER_BASE, 0, index of port 0 bit 0.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, clock.
- reset, in, 1, reset, synchronous, active-low.
- enable, in, 1, capture enable.
- valid, in, NUM_PORTS*PORT_W, per-bit toggle hits; port p occupies bits [p*PORT_W +: PORT_W].
- out_valid, out, 1, cover index available.
- out_ready, in, 1, consumer accepts.
- out_index, out, IDX_W, reported cover index.
- merged_cnt, out, 16, hits merged into an already-pending bit.
- busy, out, 1, any pending bit or out_valid.

Function
REQ-003 Each bit b of each port p SHALL have one pending flag.
- In a cycle with enable=1 and valid[p*PORT_W+b]=1, the flag SHALL be set at the next edge.
REQ-004 Index mapping SHALL be out_index = COVER_BASE + p*PORT_W + b, truncated to IDX_W.
REQ-005 Port selection SHALL be round-robin among ports with any pending flag.
- Priority starts after the last granted port; after reset it starts at port 0.
- Within the granted port, the lowest set bit SHALL be selected.
REQ-006 Output register load:
- Condition: out_valid=0, or out_valid=1 and out_ready=1.
- If any flag is pending, the selected index SHALL load into out_index, out_valid SHALL be 1, and the selected flag SHALL clear, all at the same edge.
- If no flag is pending, out_valid SHALL go to 0.
REQ-007 While out_valid=1 and out_ready=0, out_valid and out_index SHALL hold stable.
REQ-008 Latency: a hit in cycle n on an idle block SHALL give out_valid=1 in cycle n+2.
- With out_ready held 1, throughput SHALL be one index per cycle.
REQ-009 If a flag is cleared by selection and set by a new hit at the same edge, the flag SHALL remain set.
REQ-010 A hit on a flag already set, and not being cleared that cycle, SHALL increment merged_cnt by 1 per bit.
- merged_cnt SHALL saturate at 0xFFFF.
REQ-011 With enable=0, no new flags SHALL be set; pending flags SHALL continue to drain.
REQ-012 busy SHALL equal (any pending flag) OR out_valid, registered state only.

Reset
REQ-013 With reset=0 at an edge, the following SHALL clear, overriding all other updates that edge:
- all pending flags;
- out_valid=0, out_index=0;
- merged_cnt=0;
- round-robin pointer reset to port 0;
- hit mask, if present.
REQ-014 Reset asserted mid-transfer SHALL discard the in-flight index without handshake.

Configuration
REQ-015 When COVER_DEDUP_EN is defined:
- A per-bit hit mask SHALL be set when the bit's flag is set.
- Later hits on masked bits SHALL be ignored: no flag set, no merged_cnt increment.
- Each index SHALL therefore be reported at most once between resets.
REQ-016 When COVER_DEDUP_EN is undefined, no hit mask SHALL exist and every non-merged hit SHALL be reported.

Structure
REQ-017 Package cover_pkg SHALL hold:
- COVER_TOTAL (9715);
- the cover index typedef of width IDX_W;
- the merged-counter width constant.
REQ-018 Port selection SHALL live in sub-module cover_rr_arbiter.
- Inputs: NUM_PORTS request lines and the pointer.
- Outputs: one-hot grant and next pointer.

Verification
REQ-019 Single hit: valid[6]=1 for 1 cycle, out_ready=1 -> out_valid=1 in cycle n+2 with out_index=6, then out_valid=0.
REQ-020 Round-robin: ports 0, 1 and 3 all hit bit 0 in the same cycle -> indices 0, 4, 12 on consecutive cycles.
REQ-021 Backpressure: out_ready=0 for 5 cycles with index 2 presented -> out_index stays 2; ready=1 -> index 2 accepted once.
REQ-022 Merge: valid[1] high 3 consecutive cycles, out_ready=0 -> one report of index 1, merged_cnt=2.
REQ-023 Reset mid-stream: 8 flags pending, reset=0 for 1 cycle -> out_valid=0, busy=0, merged_cnt=0 next cycle.
REQ-024 Dedup build: hit valid[5] twice 10 cycles apart -> with COVER_DEDUP_EN one report; without it two reports.
